// File: rtl/pop_sort_pkg.sv
// Shared definitions for the population rank sorter: FSM state encoding and
// an elaboration-time ceil(log2) helper.
package pop_sort_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pop_argsel.sv
// Combinational best-of-unused selector: smallest (or largest) key among
// entries whose used bit is clear, lowest index winning on ties.
module pop_argsel
    import pop_sort_pkg::*;
#(
    parameter int unsigned N_ENT   = 50,
    parameter int unsigned KEY_W   = 12,
    parameter int unsigned DESCEND = 0,
    localparam int unsigned IDX_W  = (clog2(N_ENT) < 1) ? 1 : clog2(N_ENT)
) (
    input  logic [N_ENT*KEY_W-1:0] keys,
    input  logic [N_ENT-1:0]       used,
    output logic [IDX_W-1:0]       idx,
    output logic [KEY_W-1:0]       key
);

    logic             found;
    logic [KEY_W-1:0] cur;
    logic [KEY_W-1:0] best_key;
    logic [IDX_W-1:0] best_idx;

    // Strict comparison keeps the earlier (lower) index on equal keys.
    always_comb begin
        found    = 1'b0;
        cur      = '0;
        best_key = '0;
        best_idx = '0;
        for (int unsigned i = 0; i < N_ENT; i++) begin
            cur = keys[i*KEY_W +: KEY_W];
            if (!used[i]) begin
                if (!found || ((DESCEND != 0) ? (cur > best_key) : (cur < best_key))) begin
                    best_idx = IDX_W'(i);
                    best_key = cur;
                    found    = 1'b1;
                end
            end
        end
    end

    assign idx = best_idx;
    assign key = best_key;

endmodule

// File: rtl/pop_rank_sorter.sv
// Iterative selection sorter: one rank per cycle from a latched key snapshot,
// streaming each rank and accumulating the full ranked index list.
module pop_rank_sorter
    import pop_sort_pkg::*;
#(
    parameter int unsigned N_ENT   = 50,
    parameter int unsigned KEY_W   = 12,
    parameter int unsigned DESCEND = 0,
    localparam int unsigned IDX_W  = (clog2(N_ENT) < 1) ? 1 : clog2(N_ENT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_ENT*KEY_W-1:0] keys_in,
    output logic                   busy,
    output logic                   done,
    output logic                   rank_valid,
    output logic [IDX_W-1:0]       rank_num,
    output logic [IDX_W-1:0]       rank_idx,
    output logic [KEY_W-1:0]       rank_key,
    output logic [N_ENT*IDX_W-1:0] sorted
);

    state_t                 state_q, state_d;
    logic [N_ENT*KEY_W-1:0] keys_q, keys_d;
    logic [N_ENT-1:0]       used_q, used_d;
    logic [IDX_W:0]         cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rank_valid_q, rank_valid_d;
    logic [IDX_W-1:0]       rank_num_q, rank_num_d;
    logic [IDX_W-1:0]       rank_idx_q, rank_idx_d;
    logic [KEY_W-1:0]       rank_key_q, rank_key_d;
    logic [N_ENT*IDX_W-1:0] sorted_q, sorted_d;

    logic [IDX_W-1:0]       sel_idx;
    logic [KEY_W-1:0]       sel_key;

    pop_argsel #(
        .N_ENT   (N_ENT),
        .KEY_W   (KEY_W),
        .DESCEND (DESCEND)
    ) u_argsel (
        .keys (keys_q),
        .used (used_q),
        .idx  (sel_idx),
        .key  (sel_key)
    );

    always_comb begin
        state_d      = state_q;
        keys_d       = keys_q;
        used_d       = used_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        rank_valid_d = 1'b0;
        rank_num_d   = rank_num_q;
        rank_idx_d   = rank_idx_q;
        rank_key_d   = rank_key_q;
        sorted_d     = sorted_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SORT;
                    keys_d  = keys_in;
                    used_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            SORT: begin
                rank_valid_d = 1'b1;
                rank_num_d   = cnt_q[IDX_W-1:0];
                rank_idx_d   = sel_idx;
                rank_key_d   = sel_key;
                cnt_d        = cnt_q + 1'b1;
                // Decoded writes keep indices in range for non-power-of-two N_ENT.
                for (int unsigned e = 0; e < N_ENT; e++) begin
                    if (sel_idx == IDX_W'(e)) used_d[e] = 1'b1;
                    if (cnt_q == (IDX_W+1)'(e)) sorted_d[e*IDX_W +: IDX_W] = sel_idx;
                end
                if (cnt_q == (IDX_W+1)'(N_ENT - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            keys_q       <= '0;
            used_q       <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rank_valid_q <= 1'b0;
            rank_num_q   <= '0;
            rank_idx_q   <= '0;
            rank_key_q   <= '0;
            sorted_q     <= '0;
        end else begin
            state_q      <= state_d;
            keys_q       <= keys_d;
            used_q       <= used_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rank_valid_q <= rank_valid_d;
            rank_num_q   <= rank_num_d;
            rank_idx_q   <= rank_idx_d;
            rank_key_q   <= rank_key_d;
            sorted_q     <= sorted_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rank_valid = rank_valid_q;
    assign rank_num   = rank_num_q;
    assign rank_idx   = rank_idx_q;
    assign rank_key   = rank_key_q;
    assign sorted     = sorted_q;

endmodule

// File: tb/tb_pop_rank_sorter.sv
// Directed bench for pop_rank_sorter: ascending, descending and single-entry
// instances driven from shared control with hand-computed expectations.
module tb_pop_rank_sorter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [47:0] keys_in = '0;
    logic [11:0] keys_one = '0;

    logic        busy_a, done_a, rv_a;
    logic [1:0]  rnum_a, ridx_a;
    logic [11:0] rkey_a;
    logic [7:0]  sorted_a;

    logic        busy_d, done_d, rv_d;
    logic [1:0]  rnum_d, ridx_d;
    logic [11:0] rkey_d;
    logic [7:0]  sorted_d;

    logic        busy_o, done_o, rv_o;
    logic [0:0]  rnum_o, ridx_o;
    logic [11:0] rkey_o;
    logic [0:0]  sorted_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    pop_rank_sorter #(.N_ENT(4), .KEY_W(12), .DESCEND(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .keys_in(keys_in),
        .busy(busy_a), .done(done_a), .rank_valid(rv_a), .rank_num(rnum_a),
        .rank_idx(ridx_a), .rank_key(rkey_a), .sorted(sorted_a)
    );

    pop_rank_sorter #(.N_ENT(4), .KEY_W(12), .DESCEND(1)) dut_d (
        .clk(clk), .rst(rst), .start(start), .keys_in(keys_in),
        .busy(busy_d), .done(done_d), .rank_valid(rv_d), .rank_num(rnum_d),
        .rank_idx(ridx_d), .rank_key(rkey_d), .sorted(sorted_d)
    );

    pop_rank_sorter #(.N_ENT(1), .KEY_W(12), .DESCEND(0)) dut_one (
        .clk(clk), .rst(rst), .start(start), .keys_in(keys_one),
        .busy(busy_o), .done(done_o), .rank_valid(rv_o), .rank_num(rnum_o),
        .rank_idx(ridx_o), .rank_key(rkey_o), .sorted(sorted_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then follows six edges checking the stream on dut_a/dut_d.
    task automatic run_sort(input logic [47:0] keys, input logic [7:0] exp_idx,
                            input logic [7:0] exp_idx_d, input logic [47:0] exp_key,
                            input bit disturb, input bit check_one);
        int unsigned strobes;
        strobes  = 0;
        keys_in  = keys;
        keys_one = keys[11:0];
        start    = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 64'(busy_a), 64'(1));
        check("rv_after_start", 64'(rv_a), 64'(0));
        for (int c = 0; c < 6; c++) begin
            step();
            if (rv_a) strobes++;
            if (c < 4) begin
                check("rank_valid", 64'(rv_a), 64'(1));
                check("rank_num", 64'(rnum_a), 64'(c));
                check("rank_idx", 64'(ridx_a), 64'(exp_idx[c*2 +: 2]));
                check("rank_key", 64'(rkey_a), 64'(exp_key[c*12 +: 12]));
                check("rank_idx_desc", 64'(ridx_d), 64'(exp_idx_d[c*2 +: 2]));
                check("done_timing", 64'(done_a), 64'(c == 3));
            end
            if (check_one && c == 0) begin
                check("one_rv", 64'(rv_o), 64'(1));
                check("one_done", 64'(done_o), 64'(1));
                check("one_key", 64'(rkey_o), 64'(keys[11:0]));
            end
            if (check_one && c == 1) begin
                check("one_rv_low", 64'(rv_o), 64'(0));
                check("one_sorted", 64'(sorted_o), 64'(0));
            end
            if (disturb && c == 0) begin
                start   = 1'b1;
                keys_in = '0;
            end
            if (disturb && c == 1) start = 1'b0;
        end
        check("strobe_count", 64'(strobes), 64'(4));
        check("sorted", 64'(sorted_a), 64'(exp_idx));
        check("sorted_desc", 64'(sorted_d), 64'(exp_idx_d));
        check("done_hold", 64'(done_a), 64'(1));
    endtask

    localparam logic [47:0] K_BASE  = {12'd9, 12'd3, 12'd3, 12'd7};
    localparam logic [7:0]  I_BASE  = {2'd3, 2'd0, 2'd2, 2'd1};
    localparam logic [7:0]  ID_BASE = {2'd2, 2'd1, 2'd0, 2'd3};
    localparam logic [47:0] E_BASE  = {12'd9, 12'd7, 12'd3, 12'd3};

    initial begin
        logic [7:0]  i_b2b;
        logic [47:0] k_b2b;
        logic [31:0] s_b2b;
        bit          seen;

        i_b2b = {2'd0, 2'd2, 2'd3, 2'd1};
        k_b2b = {12'd5, 12'd4, 12'd2, 12'd1};
        s_b2b = {8'h2D, 8'hED, 8'hCD, 8'hC9};

        // Reset, with start asserted alongside it.
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        rst   = 1'b0;
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_done", 64'(done_a), 64'(0));
        check("rst_rv", 64'(rv_a), 64'(0));
        check("rst_rank", 64'({rnum_a, ridx_a, rkey_a}), 64'(0));
        check("rst_sorted", 64'(sorted_a), 64'(0));
        step();
        check("idle_busy", 64'(busy_a), 64'(0));

        run_sort(K_BASE, I_BASE, ID_BASE, E_BASE, 1'b0, 1'b1);

        run_sort({4{12'hFFF}}, {2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd2, 2'd1, 2'd0},
                 {4{12'hFFF}}, 1'b0, 1'b0);

        run_sort(K_BASE, I_BASE, ID_BASE, E_BASE, 1'b1, 1'b0);
        // Let the restarted single-entry instance settle before the reset test.
        step();
        step();

        // Reset when rank_num=2 is on the outputs.
        keys_in = K_BASE;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("pre_rst_rank_num", 64'(rnum_a), 64'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 64'(busy_a), 64'(0));
        check("midrst_done", 64'(done_a), 64'(0));
        check("midrst_rv", 64'(rv_a), 64'(0));
        check("midrst_sorted", 64'(sorted_a), 64'(0));
        step();
        check("midrst_idle", 64'(busy_a), 64'(0));
        run_sort(K_BASE, I_BASE, ID_BASE, E_BASE, 1'b0, 1'b0);

        // Start held high from DONE: immediate second sort, old list overwritten rank by rank.
        keys_in = {12'd2, 12'd4, 12'd1, 12'd5};
        start   = 1'b1;
        step();
        check("b2b_busy", 64'(busy_a), 64'(1));
        check("b2b_done_low", 64'(done_a), 64'(0));
        check("b2b_sorted_kept", 64'(sorted_a), 64'(8'hC9));
        for (int c = 0; c < 4; c++) begin
            step();
            check("b2b_rank_idx", 64'(ridx_a), 64'(i_b2b[c*2 +: 2]));
            check("b2b_rank_key", 64'(rkey_a), 64'(k_b2b[c*12 +: 12]));
            check("b2b_sorted", 64'(sorted_a), 64'(s_b2b[c*8 +: 8]));
        end
        check("b2b_done", 64'(done_a), 64'(1));
        step();
        check("b2b_restart_busy", 64'(busy_a), 64'(1));
        check("b2b_restart_rv", 64'(rv_a), 64'(0));
        check("b2b_restart_sorted", 64'(sorted_a), 64'(8'h2D));
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (done_a) seen = 1'b1;
        end
        check("b2b_final_done", 64'(seen), 64'(1));
        check("b2b_final_sorted", 64'(sorted_a), 64'(8'h2D));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pop_rank_sorter.md
POP_RANK_SORTER -- requirements
Module: pop_rank_sorter

Interface
REQ-001 Parameter N_ENT, default 50: number of population entries to rank.
REQ-002 Parameter KEY_W, default 12: width of each key (fitness or distance) in bits.
REQ-003 Parameter DESCEND, default 0: 0 ranks smallest key first, 1 ranks largest key first.
REQ-004 Derived constant IDX_W = clog2(N_ENT), minimum 1: width of an entry index.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  request to sort; sampled only in IDLE and DONE.
REQ-008 keys_in  in  N_ENT*KEY_W  flat key vector; entry i occupies bits [i*KEY_W +: KEY_W].
REQ-009 busy  out  1  high while in SORT.
REQ-010 done  out  1  high while in DONE.
REQ-011 rank_valid  out  1  one-cycle strobe per emitted rank.
REQ-012 rank_num  out  IDX_W  rank position of the current strobe, 0 = best.
REQ-013 rank_idx  out  IDX_W  entry index selected for rank_num.
REQ-014 rank_key  out  KEY_W  key value of rank_idx.
REQ-015 sorted  out  N_ENT*IDX_W  full ranked index list; rank r occupies bits [r*IDX_W +: IDX_W].

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SORT and DONE.
REQ-017 In IDLE with start=1, the block SHALL latch keys_in, clear the used mask and rank counter, and enter SORT.
REQ-018 In SORT, each cycle SHALL select, among unused entries, the minimum key (maximum key if DESCEND=1).
REQ-019 On a key tie, the lowest index SHALL win.
REQ-020 The selected entry SHALL be marked used in a per-entry used mask; keys SHALL never be overwritten with sentinels.
REQ-021 Every key value, including all-ones, SHALL be ranked correctly.
REQ-022 Each SORT cycle SHALL register the following at the edge ending that cycle, so they are visible the next cycle: rank_valid=1, rank_num=counter, rank_idx=selection, rank_key=selected key, and sorted[counter]=selection.
REQ-023 SORT SHALL last exactly N_ENT cycles.
REQ-024 After the final selection (counter = N_ENT-1), the FSM SHALL enter DONE.
REQ-025 done SHALL first assert N_ENT+1 rising edges after the edge that sampled start.
REQ-026 The last rank_valid strobe SHALL be coincident with the first done cycle.
REQ-027 rank_valid SHALL be low in every cycle other than the N_ENT strobe cycles.
REQ-028 In DONE, sorted SHALL hold stable.
REQ-029 In DONE with start=1, the block SHALL behave as in IDLE with start=1 (back-to-back sorts).
REQ-030 In DONE with start=0, the block SHALL remain in DONE.
REQ-031 start asserted during SORT SHALL be ignored.
REQ-032 keys_in changes during SORT SHALL have no effect.
REQ-033 sorted SHALL retain the previous result until overwritten rank by rank during a new SORT.
REQ-034 The rank counter SHALL be IDX_W+1 bits wide and SHALL NOT wrap within a sort.
REQ-035 Key comparison SHALL be unsigned over the full KEY_W bits.
REQ-036 With N_ENT=1, SORT SHALL last one cycle and SHALL produce sorted=0.

Reset
REQ-037 When rst=1 at a rising edge, the FSM SHALL enter IDLE regardless of state, including mid-SORT.
REQ-038 The same reset edge SHALL clear busy, done, rank_valid, rank_num, rank_idx, rank_key and sorted to 0, and clear the used mask and counter.
REQ-039 rst SHALL take priority over start in the same cycle.
REQ-040 The block SHALL contain no initial-block-dependent state; all registers are defined by rst.

Structure
REQ-041 Shared package pop_sort_pkg SHALL hold the FSM state enum (IDLE/SORT/DONE) and a clog2 function; no other contents.
REQ-042 The combinational best-of-unused selector SHALL be one sub-module, pop_argsel.
REQ-043 pop_argsel SHALL take parameters N_ENT, KEY_W and DESCEND, have inputs keys and used mask, and have outputs idx and key.
REQ-044 The selection path SHALL be unregistered within a cycle; pipelining is not required.

Verification (N_ENT=4, KEY_W=12 unless noted)
REQ-045 keys={7,3,3,9} (entry0..3), DESCEND=0, start pulse -> rank_idx sequence 1,2,0,3 and rank_key sequence 3,3,7,9 on consecutive cycles; done on the 5th edge after start; sorted={1,2,0,3}.
REQ-046 Same keys, DESCEND=1 -> rank_idx sequence 3,0,1,2.
REQ-047 keys all 4095 -> rank_idx sequence 0,1,2,3 with every index emitted exactly once.
REQ-048 Start pulse at rank 1 of SORT and keys_in changed mid-sort -> output sequence unchanged from REQ-045; exactly 4 strobes.
REQ-049 rst asserted when rank_num=2 -> next cycle state IDLE with busy=0, done=0, rank_valid=0 and sorted=0; a fresh start then yields the REQ-045 result.
REQ-050 Start held high in DONE with keys={5,1,4,2} -> immediate second sort; rank_idx sequence 1,3,2,0; first-sort sorted value stable until overwritten.
